// File: rtl/uart_tx_frame.sv
// UART transmitter: DATA_BITS data bits LSB first, STOP_BITS stop bits, valid/ready input with zero-gap chaining.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1) between data and stop.
module uart_tx_frame #(
    parameter int DIVIDER    = 217,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_25mhz,
    input  logic                 resetn,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam int BAUD_W = $clog2(DIVIDER);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVIDER - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (DIVIDER < 2) begin : g_bad_divider
        $error("uart_tx_frame: DIVIDER must be at least 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state,    w_state_next;
    logic [BAUD_W-1:0]    r_baud_cnt, w_baud_next;
    logic [BIT_W-1:0]     r_bit_cnt,  w_bit_next;
    logic [DATA_BITS-1:0] r_shift,    w_shift_next;
    logic                 r_tx,       w_tx_next;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity,   w_parity_next;
`endif

    logic w_bit_end;
    logic w_last_stop;
    logic w_accept;

    assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bit_cnt == STOP_LAST);
    assign w_accept    = in_valid && in_ready;

    assign in_ready = (r_state == S_IDLE) || w_last_stop;
    assign busy     = (r_state != S_IDLE);
    assign tx       = r_tx;
    // A reset landing on the final stop cycle must not leak a completion pulse.
    assign tx_done  = w_last_stop && resetn;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path through the case infers a latch.
        w_state_next = r_state;
        w_baud_next  = w_bit_end ? '0 : r_baud_cnt + 1'b1;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
`ifdef UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif

        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                w_tx_next   = 1'b1;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_bit_next   = '0;
                    w_tx_next    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == DATA_LAST) begin
                        w_bit_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
                        w_tx_next    = r_parity;
`else
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
`endif
                    end else begin
                        w_bit_next   = r_bit_cnt + 1'b1;
                        w_shift_next = r_shift >> 1;
                        w_tx_next    = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_bit_next   = '0;
                    w_tx_next    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == STOP_LAST) begin
                        w_state_next = S_IDLE;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase

        // Accept overrides the above, which is what lets STOP chain straight into START.
        if (w_accept) begin
            w_state_next = S_START;
            w_baud_next  = '0;
            w_bit_next   = '0;
            w_shift_next = in_data;
            w_tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_parity_next = (^in_data) ^ 1'(PARITY_ODD);
`endif
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8-1 instance plus two 7-2 instances (even / odd parity setting),
// all at DIVIDER=4, checked cycle by cycle against a bit-list model of the frame.
module tb_uart_tx_frame;

    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk_25mhz = 1'b0;
    always #20 clk_25mhz = ~clk_25mhz;

    logic       resetn;
    logic [7:0] data_a;
    logic [6:0] data_b, data_c;
    logic       valid_a, ready_a, tx_a, busy_a, done_a;
    logic       valid_b, ready_b, tx_b, busy_b, done_b;
    logic       valid_c, ready_c, tx_c, busy_c, done_c;

    int n_checks = 0;
    int n_fails  = 0;

    uart_tx_frame #(.DIVIDER(DIV), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut_a (
        .clk_25mhz(clk_25mhz), .resetn(resetn), .in_data(data_a), .in_valid(valid_a),
        .in_ready(ready_a), .tx(tx_a), .busy(busy_a), .tx_done(done_a)
    );
    uart_tx_frame #(.DIVIDER(DIV), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u_dut_b (
        .clk_25mhz(clk_25mhz), .resetn(resetn), .in_data(data_b), .in_valid(valid_b),
        .in_ready(ready_b), .tx(tx_b), .busy(busy_b), .tx_done(done_b)
    );
    uart_tx_frame #(.DIVIDER(DIV), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) u_dut_c (
        .clk_25mhz(clk_25mhz), .resetn(resetn), .in_data(data_c), .in_valid(valid_c),
        .in_ready(ready_c), .tx(tx_c), .busy(busy_c), .tx_done(done_c)
    );

    function automatic int data_bits(int d);
        return (d == 0) ? 8 : 7;
    endfunction

    function automatic int frame_cycles(int d);
        return (1 + data_bits(d) + P + ((d == 0) ? 1 : 2)) * DIV;
    endfunction

    function automatic logic [8:0] rnd_word(int d);
        return (d == 0) ? 9'($urandom & 32'hFF) : 9'($urandom & 32'h7F);
    endfunction

    // Expected line level for bit slot k of a frame carrying word w.
    function automatic logic exp_bit(int d, logic [8:0] w, int k);
        int db;
        db = data_bits(d);
        if (k == 0) return 1'b0;
        if (k <= db) return w[k-1];
        if (P == 1 && k == db + 1) return (($countones(w) % 2) == 1) ^ (d == 2);
        return 1'b1;
    endfunction

    // Packed as {tx, busy, in_ready, tx_done}.
    function automatic logic [3:0] outs(int d);
        case (d)
            0:       return {tx_a, busy_a, ready_a, done_a};
            1:       return {tx_b, busy_b, ready_b, done_b};
            default: return {tx_c, busy_c, ready_c, done_c};
        endcase
    endfunction

    task automatic drive(int d, logic v, logic [8:0] w);
        case (d)
            0:       begin valid_a = v; data_a = w[7:0]; end
            1:       begin valid_b = v; data_b = w[6:0]; end
            default: begin valid_c = v; data_c = w[6:0]; end
        endcase
    endtask

    // Entered on the first falling edge after accept; leaves on the falling edge after the tx_done cycle.
    task automatic run_frame(int d, logic [8:0] w, logic nxt_v, logic [8:0] nxt_w, int noise_c);
        int fl;
        logic [3:0] exp;
        fl = frame_cycles(d);
        for (int c = 0; c < fl; c++) begin
            exp = {exp_bit(d, w, c / DIV), 1'b1, c == fl - 1, c == fl - 1};
            n_checks++;
            if (outs(d) !== exp) begin
                n_fails++;
                $display("FAIL frame dut%0d word=%h cycle %0d: {tx,busy,ready,done}=%b expected %b",
                         d, w, c, outs(d), exp);
            end
            if (c == fl - 1)       drive(d, nxt_v, nxt_w);
            else if (c == noise_c) drive(d, 1'b1, 9'h055);
            else                   drive(d, 1'b0, 9'($urandom));
            @(negedge clk_25mhz);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_25mhz);
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (outs(d) !== 4'b1010) begin
                    n_fails++;
                    $display("FAIL reset dut%0d cycle %0d: {tx,busy,ready,done}=%b expected 1010", d, i, outs(d));
                end
            end
        end
        resetn = 1'b1;
        @(negedge clk_25mhz);
    endtask

    task automatic test_single();
        n_checks++;
        if (ready_a !== 1'b1) begin
            n_fails++;
            $display("FAIL single idle in_ready=%b expected 1", ready_a);
        end
        drive(0, 1'b1, 9'h0A5);
        @(negedge clk_25mhz);
        run_frame(0, 9'h0A5, 1'b0, 9'h000, -1);
        n_checks++;
        if (outs(0) !== 4'b1010) begin
            n_fails++;
            $display("FAIL single after-frame {tx,busy,ready,done}=%b expected 1010", outs(0));
        end
        repeat (3) @(negedge clk_25mhz);
    endtask

    task automatic test_back_to_back();
        drive(0, 1'b1, 9'h000);
        @(negedge clk_25mhz);
        run_frame(0, 9'h000, 1'b1, 9'h0FF, -1);
        run_frame(0, 9'h0FF, 1'b0, 9'h000, -1);
        n_checks++;
        if (outs(0) !== 4'b1010) begin
            n_fails++;
            $display("FAIL back_to_back after-frames {tx,busy,ready,done}=%b expected 1010", outs(0));
        end
        @(negedge clk_25mhz);
    endtask

    task automatic test_parity();
        for (int d = 1; d < 3; d++) begin
            drive(d, 1'b1, 9'h003);
            @(negedge clk_25mhz);
            run_frame(d, 9'h003, 1'b0, 9'h000, -1);
            n_checks++;
            if (outs(d) !== 4'b1010) begin
                n_fails++;
                $display("FAIL parity dut%0d after-frame {tx,busy,ready,done}=%b expected 1010", d, outs(d));
            end
        end
        @(negedge clk_25mhz);
    endtask

    task automatic test_ignored_input();
        drive(0, 1'b1, 9'h03C);
        @(negedge clk_25mhz);
        run_frame(0, 9'h03C, 1'b0, 9'h000, 10);
        for (int i = 0; i < 2 * DIV; i++) begin
            n_checks++;
            if (outs(0) !== 4'b1010) begin
                n_fails++;
                $display("FAIL ignored_input idle cycle %0d {tx,busy,ready,done}=%b expected 1010", i, outs(0));
            end
            @(negedge clk_25mhz);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] w;
        logic [3:0] exp;
        w = rnd_word(0);
        drive(0, 1'b1, w);
        @(negedge clk_25mhz);
        for (int c = 0; c < 18; c++) begin
            exp = {exp_bit(0, w, c / DIV), 3'b100};
            n_checks++;
            if (outs(0) !== exp) begin
                n_fails++;
                $display("FAIL reset_mid pre-reset cycle %0d {tx,busy,ready,done}=%b expected %b", c, outs(0), exp);
            end
            drive(0, 1'b0, 9'($urandom));
            if (c == 17) resetn = 1'b0;
            @(negedge clk_25mhz);
        end
        n_checks++;
        if (outs(0) !== 4'b1010) begin
            n_fails++;
            $display("FAIL reset_mid at reset {tx,busy,ready,done}=%b expected 1010", outs(0));
        end
        resetn = 1'b1;
        for (int i = 0; i < frame_cycles(0); i++) begin
            @(negedge clk_25mhz);
            n_checks++;
            if (outs(0) !== 4'b1010) begin
                n_fails++;
                $display("FAIL reset_mid after release cycle %0d {tx,busy,ready,done}=%b expected 1010", i, outs(0));
            end
        end
        w = rnd_word(0);
        drive(0, 1'b1, w);
        @(negedge clk_25mhz);
        run_frame(0, w, 1'b0, 9'h000, -1);
    endtask

    task automatic test_random();
        logic [8:0] w, nxt;
        logic chain;
        for (int d = 0; d < 3; d++) begin
            w = rnd_word(d);
            drive(d, 1'b1, w);
            @(negedge clk_25mhz);
            for (int i = 0; i < 4; i++) begin
                nxt   = rnd_word(d);
                chain = (i < 3) && ($urandom_range(0, 1) == 1);
                run_frame(d, w, chain, nxt, $urandom_range(0, frame_cycles(d) - 2));
                if (!chain) begin
                    n_checks++;
                    if (outs(d) !== 4'b1010) begin
                        n_fails++;
                        $display("FAIL random dut%0d idle {tx,busy,ready,done}=%b expected 1010", d, outs(d));
                    end
                    if (i < 3) begin
                        drive(d, 1'b1, nxt);
                        @(negedge clk_25mhz);
                    end
                end
                w = nxt;
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 9'h000);
        @(posedge clk_25mhz);
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_ignored_input();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #(40 * 20000);
        $display("FAIL timeout: bench did not complete within 20000 cycles");
        $fatal(1);
    end

endmodule
